// File: rtl/avalon_reg_if.sv
// Avalon-MM slave front-end for a bank of byte-enabled 32-bit registers.
// Every transfer is held for one wait state, then completed in a response cycle.
module avalon_reg_if #(
    parameter int NREGS = 4,
    parameter int AW    = 2
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 avs_chipselect,
    input  logic [AW-1:0]        avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    input  logic [3:0]           avs_byteenable,
    output logic [31:0]          avs_readdata,
    output logic                 avs_readdatavalid,
    output logic                 avs_waitrequest,
    output logic [31:0]          reg_D,
    output logic [4*NREGS-1:0]   reg_byteenable,
    input  logic [32*NREGS-1:0]  reg_Q,
    output logic [NREGS-1:0]     wr_strobe
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_reg;
    logic [AW-1:0] addr_reg;
    logic [31:0]   wdata_reg;
    logic [3:0]    be_reg;
    logic          is_write_reg;
    logic [31:0]   rd_mux;
    logic          wr_active;
    logic [31:0]   q_word [NREGS];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_q
            assign q_word[gi] = reg_Q[32*gi +: 32];
        end
    endgenerate

    // Out-of-range addresses match no register and read back as zero.
    always_comb begin
        rd_mux = 32'h0;
        for (int k = 0; k < NREGS; k++) begin
            if (addr_reg == AW'(k)) begin
                rd_mux = q_word[k];
            end
        end
    end

    // Gated by resetn so a reset landing in WAIT never lets a register capture.
    assign wr_active = (state_reg == WAIT) && is_write_reg && resetn;

    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_wr
            assign reg_byteenable[4*gi +: 4] =
                (wr_active && (addr_reg == AW'(gi))) ? be_reg : 4'h0;
            assign wr_strobe[gi] =
                wr_active && (addr_reg == AW'(gi)) && (be_reg != 4'h0);
        end
    endgenerate

    assign reg_D           = wdata_reg;
    assign avs_waitrequest = (state_reg != RESP);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg         <= IDLE;
            addr_reg          <= '0;
            wdata_reg         <= 32'h0;
            be_reg            <= 4'h0;
            is_write_reg      <= 1'b0;
            avs_readdata      <= 32'h0;
            avs_readdatavalid <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    avs_readdatavalid <= 1'b0;
                    if (avs_chipselect && (avs_read || avs_write)) begin
                        addr_reg     <= avs_address;
                        wdata_reg    <= avs_writedata;
                        be_reg       <= avs_byteenable;
                        is_write_reg <= avs_write;
                        state_reg    <= WAIT;
                    end
                end
                WAIT: begin
                    state_reg <= RESP;
                    if (!is_write_reg) begin
                        avs_readdata      <= rd_mux;
                        avs_readdatavalid <= 1'b1;
                    end
                end
                RESP: begin
                    state_reg         <= IDLE;
                    avs_readdatavalid <= 1'b0;
                end
                default: begin
                    state_reg         <= IDLE;
                    avs_readdatavalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_reg_if.sv
// Directed bench for avalon_reg_if with a behavioral byte-enabled register bank.
module tb_avalon_reg_if;

    localparam int NREGS = 3;
    localparam int AW    = 2;

    logic                 clock = 1'b0;
    logic                 resetn;
    logic                 avs_chipselect;
    logic [AW-1:0]        avs_address;
    logic                 avs_read;
    logic                 avs_write;
    logic [31:0]          avs_writedata;
    logic [3:0]           avs_byteenable;
    logic [31:0]          avs_readdata;
    logic                 avs_readdatavalid;
    logic                 avs_waitrequest;
    logic [31:0]          reg_D;
    logic [4*NREGS-1:0]   reg_byteenable;
    logic [32*NREGS-1:0]  reg_Q;
    logic [NREGS-1:0]     wr_strobe;

    logic [31:0] bank [NREGS] = '{default: 32'h0};
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    avalon_reg_if #(.NREGS(NREGS), .AW(AW)) dut (
        .clock(clock), .resetn(resetn),
        .avs_chipselect(avs_chipselect), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
        .avs_waitrequest(avs_waitrequest), .reg_D(reg_D),
        .reg_byteenable(reg_byteenable), .reg_Q(reg_Q), .wr_strobe(wr_strobe)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        for (int k = 0; k < NREGS; k++)
            for (int b = 0; b < 4; b++)
                if (reg_byteenable[4*k+b]) bank[k][8*b +: 8] <= reg_D[8*b +: 8];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_bank
            assign reg_Q[32*gi +: 32] = bank[gi];
        end
    endgenerate

    typedef struct {
        bit          wr;
        bit          rd;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [11:0] exp_be;
        logic [2:0]  exp_st;
        bit          exp_rdv;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_xfer(input bit wr, input bit rd, input logic [1:0] addr,
                           input logic [31:0] data, input logic [3:0] be,
                           output int lat, output logic [11:0] be_or,
                           output logic [2:0] st_or, output int st_cnt,
                           output int rdv_cnt, output logic [31:0] rdata,
                           output int resp_cyc);
        lat = 0; be_or = '0; st_or = '0; st_cnt = 0; rdv_cnt = 0;
        rdata = 'x; resp_cyc = -1;
        @(negedge clock);
        avs_chipselect = 1'b1; avs_write = wr; avs_read = rd;
        avs_address = addr; avs_writedata = data; avs_byteenable = be;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            be_or = be_or | reg_byteenable;
            st_or = st_or | wr_strobe;
            if (wr_strobe != '0) st_cnt++;
            if (avs_readdatavalid) rdv_cnt++;
            if (!avs_waitrequest) begin
                lat = c;
                rdata = avs_readdata;
                resp_cyc = cyc;
                break;
            end
        end
        @(posedge clock);
        #1;
        avs_chipselect = 1'b0; avs_write = 1'b0; avs_read = 1'b0;
    endtask

    vec_t vecs [13];
    int lat, st_cnt, rdv_cnt, resp_cyc, prev_resp;
    logic [11:0] be_or;
    logic [2:0] st_or;
    logic [31:0] rdata;

    initial begin
        vecs[0]  = '{1, 0, 2'd2, 32'hCAFE_F00D, 4'hF, 12'hF00, 3'b100, 0, 32'h0};
        vecs[1]  = '{0, 1, 2'd2, 32'h0,         4'hF, 12'h000, 3'b000, 1, 32'hCAFE_F00D};
        vecs[2]  = '{1, 0, 2'd0, 32'h1111_1111, 4'hF, 12'h00F, 3'b001, 0, 32'hCAFE_F00D};
        vecs[3]  = '{1, 0, 2'd0, 32'hAABB_CCDD, 4'h5, 12'h005, 3'b001, 0, 32'hCAFE_F00D};
        vecs[4]  = '{0, 1, 2'd0, 32'h0,         4'h0, 12'h000, 3'b000, 1, 32'h11BB_11DD};
        vecs[5]  = '{1, 0, 2'd3, 32'hDEAD_BEEF, 4'hF, 12'h000, 3'b000, 0, 32'h11BB_11DD};
        vecs[6]  = '{0, 1, 2'd3, 32'h0,         4'hF, 12'h000, 3'b000, 1, 32'h0};
        vecs[7]  = '{1, 0, 2'd1, 32'h1234_5678, 4'hF, 12'h0F0, 3'b010, 0, 32'h0};
        vecs[8]  = '{1, 0, 2'd1, 32'hFFFF_FFFF, 4'h0, 12'h000, 3'b000, 0, 32'h0};
        vecs[9]  = '{0, 1, 2'd1, 32'h0,         4'hF, 12'h000, 3'b000, 1, 32'h1234_5678};
        vecs[10] = '{1, 1, 2'd1, 32'h5A5A_5A5A, 4'hF, 12'h0F0, 3'b010, 0, 32'h1234_5678};
        vecs[11] = '{0, 1, 2'd1, 32'h0,         4'hF, 12'h000, 3'b000, 1, 32'h5A5A_5A5A};
        vecs[12] = '{0, 1, 2'd2, 32'h0,         4'hF, 12'h000, 3'b000, 1, 32'hCAFE_F00D};

        // Reset held for 3 cycles with random bus activity.
        resetn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            avs_chipselect = 1'($urandom); avs_read = 1'($urandom);
            avs_write = 1'($urandom); avs_address = 2'($urandom);
            avs_writedata = $urandom; avs_byteenable = 4'($urandom);
            @(negedge clock);
            check("rst_waitrequest", 32'(avs_waitrequest), 32'h1);
            check("rst_byteenable", 32'(reg_byteenable), 32'h0);
            check("rst_strobe", 32'(wr_strobe), 32'h0);
            check("rst_readdatavalid", 32'(avs_readdatavalid), 32'h0);
            check("rst_readdata", avs_readdata, 32'h0);
            check("rst_reg_D", reg_D, 32'h0);
            $display("reset cycle %0d: waitrequest=%b be=%h strobe=%b", c, avs_waitrequest,
                     reg_byteenable, wr_strobe);
        end
        avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
        resetn = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 13; i++) begin
            do_xfer(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].be,
                    lat, be_or, st_or, st_cnt, rdv_cnt, rdata, resp_cyc);
            $display("vec %0d wr=%b rd=%b addr=%0d data=%h be=%h: lat=%0d be=%h st=%b rdv=%0d rdata=%h",
                     i, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].be,
                     lat, be_or, st_or, rdv_cnt, rdata);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("v%0d_byteenable", i), 32'(be_or), 32'(vecs[i].exp_be));
            check($sformatf("v%0d_strobe", i), 32'(st_or), 32'(vecs[i].exp_st));
            check($sformatf("v%0d_strobe_cycles", i), 32'(st_cnt),
                  (vecs[i].exp_st != 0) ? 32'd1 : 32'd0);
            check($sformatf("v%0d_readdatavalid", i), 32'(rdv_cnt), 32'(vecs[i].exp_rdv));
            check($sformatf("v%0d_readdata", i), rdata, vecs[i].exp_rdata);
        end
        check("bank0_after_partial", bank[0], 32'h11BB_11DD);

        // Reset during the WAIT cycle of a write must abort it.
        @(negedge clock);
        avs_chipselect = 1'b1; avs_write = 1'b1; avs_read = 1'b0;
        avs_address = 2'd0; avs_writedata = 32'h0; avs_byteenable = 4'hF;
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check("midrst_byteenable", 32'(reg_byteenable), 32'h0);
        check("midrst_strobe", 32'(wr_strobe), 32'h0);
        @(negedge clock);
        avs_chipselect = 1'b0; avs_write = 1'b0;
        check("midrst_waitrequest", 32'(avs_waitrequest), 32'h1);
        check("midrst_bank0", bank[0], 32'h11BB_11DD);
        $display("mid-transfer reset: bank0=%h", bank[0]);
        resetn = 1'b1;
        do_xfer(0, 1, 2'd0, 32'h0, 4'hF, lat, be_or, st_or, st_cnt, rdv_cnt, rdata, resp_cyc);
        check("midrst_read_rdv", 32'(rdv_cnt), 32'h1);
        check("midrst_read_data", rdata, 32'h11BB_11DD);
        $display("read after reset: rdata=%h", rdata);

        // Back-to-back alternating writes and reads, master re-requests at once.
        prev_resp = -1;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] d;
            d = 32'h1000_0000 + 32'(i / 2);
            if (i % 2 == 0)
                do_xfer(1, 0, 2'd2, d, 4'hF, lat, be_or, st_or, st_cnt, rdv_cnt, rdata, resp_cyc);
            else
                do_xfer(0, 1, 2'd2, 32'h0, 4'hF, lat, be_or, st_or, st_cnt, rdv_cnt, rdata, resp_cyc);
            $display("b2b %0d %s: resp_cyc=%0d rdv=%0d rdata=%h", i,
                     (i % 2 == 0) ? "write" : "read", resp_cyc, rdv_cnt, rdata);
            check($sformatf("b2b%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("b2b%0d_rdv", i), 32'(rdv_cnt), (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i % 2 == 1) check($sformatf("b2b%0d_rdata", i), rdata, d);
            else check($sformatf("b2b%0d_strobe", i), 32'(st_or), 32'b100);
            if (prev_resp >= 0) check($sformatf("b2b%0d_spacing", i), 32'(resp_cyc - prev_resp), 32'd3);
            prev_resp = resp_cyc;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, n_err=%0d", n_err);
        $fatal(1);
    end

endmodule
